shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, shift-register length and frame size in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid_i  input  1  upstream parallel word valid.
REQ-005 SHALL have port: in_data_i  input  WIDTH  upstream parallel word.
REQ-006 SHALL have port: in_ready_o  output  1  controller can accept a word.
REQ-007 SHALL have port: sr_en_o  output  1  shift enable to the driven shift register.
REQ-008 SHALL have port: sr_x_o  output  1  serial bit to the shift register's LSB input.
REQ-009 SHALL have port: sr_i  input  WIDTH  parallel contents read back from the shift register.
REQ-010 SHALL have port: out_valid_o  output  1  frame complete, out_data_o valid.
REQ-011 SHALL have port: out_data_o  output  WIDTH  shifted frame read back from sr_i.
REQ-012 SHALL have port: out_ready_i  input  1  downstream accepts the frame.
REQ-013 SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port: mismatch_o  output  1  sticky read-back error flag.

Function
REQ-015 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-016 IDLE: in_ready_o=1; on in_valid_i&in_ready_o, the FSM SHALL capture in_data_i into an internal word register, clear the bit counter and go to SHIFT.
REQ-017 SHIFT: sr_en_o=1 for exactly WIDTH consecutive cycles; sr_x_o SHALL equal word[WIDTH-1-cnt], so the MSB goes first and the word lands unreversed in the left-shifting register.
REQ-018 The bit counter SHALL be $clog2(WIDTH) bits wide, increment once per SHIFT cycle, and leave SHIFT for DONE when cnt==WIDTH-1, with no wrap beyond that.
REQ-019 DONE: out_valid_o=1 and out_data_o=sr_i; the FSM SHALL hold until out_valid_o&out_ready_i, then return to IDLE.
REQ-020 Latency: a word accepted at edge T SHALL give sr_en_o high in cycles T+1..T+WIDTH and out_valid_o high from cycle T+WIDTH+1.
REQ-021 in_ready_o SHALL be 0 in SHIFT and DONE; in_valid_i in those states SHALL be ignored and SHALL NOT alter the captured word.
REQ-022 out_ready_i high on the first DONE cycle SHALL complete the handshake in that cycle, giving a minimum period of WIDTH+2 cycles per word.
REQ-023 Outside SHIFT, sr_en_o=0 and sr_x_o=0; outside DONE, out_valid_o=0 and out_data_o=0.
REQ-024 out_data_o SHALL remain stable while out_valid_o=1 and out_ready_i=0, because sr_en_o is low.

Reset
REQ-025 While reset_n=0, the FSM SHALL be in IDLE, with counter=0, word register=0 and mismatch flag=0.
REQ-026 While reset_n=0, outputs SHALL be in_ready_o=0, sr_en_o=0, sr_x_o=0, out_valid_o=0, out_data_o=0, busy_o=0 and mismatch_o=0.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the frame immediately with no further sr_en_o pulses and no out_valid_o for that frame.
REQ-028 After reset_n rises, in_ready_o SHALL be 1 in the first cycle.

Configuration
REQ-029 The macro SHIFT_SEQ_CTRL_CHECK_EN SHALL control the read-back check.
REQ-030 With SHIFT_SEQ_CTRL_CHECK_EN defined, on each DONE handshake the block SHALL compare sr_i with the captured word and set mismatch_o on any difference; mismatch_o SHALL stay high until reset.
REQ-031 Without SHIFT_SEQ_CTRL_CHECK_EN defined, mismatch_o SHALL be tied to 0 and no comparator logic SHALL be present.

Verification
REQ-032 WIDTH=4, send 4'b1011 with out_ready_i=1 -> sr_x_o sequence 1,0,1,1 in cycles T+1..T+4; out_valid_o at T+5 with out_data_o=4'b1011; in_ready_o back to 1 at T+6.
REQ-033 Send 4'hA, hold out_ready_i=0 for 3 cycles -> out_valid_o held 4 cycles with out_data_o=4'hA throughout; in_valid_i with 4'h5 during this time is ignored.
REQ-034 Send back-to-back words 4'h3 and 4'hC with in_valid_i held high -> second acceptance exactly 6 cycles after the first; outputs 4'h3 then 4'hC.
REQ-035 Assert reset_n=0 after the second SHIFT cycle -> sr_en_o=0 immediately, no out_valid_o; after release, new word 4'h6 completes normally.
REQ-036 With SHIFT_SEQ_CTRL_CHECK_EN defined, force one sr_i bit wrong in DONE -> mismatch_o=1 after the handshake and stays 1 until reset; without the macro, mismatch_o stays 0.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: feeds a parallel word MSB-first into an external
// left-shifting register, then presents the register's read-back
// contents downstream with a valid/ready handshake.
// Optional macro SHIFT_SEQ_CTRL_CHECK_EN adds a sticky read-back
// comparison (mismatch_o); without it mismatch_o is tied low.
module shift_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             sr_en_o,
    output logic             sr_x_o,
    input  logic [WIDTH-1:0] sr_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             mismatch_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             accept;

    // Ready is gated by reset so the block advertises nothing while held
    // in reset, yet is ready in the very first cycle after release.
    assign in_ready_o = reset_n & (state_reg == IDLE);
    assign accept     = in_valid_i & in_ready_o;
    assign busy_o     = (state_reg != IDLE);

    // State, bit counter and captured word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        word_next   = word_reg;
        sr_en_o     = 1'b0;
        sr_x_o      = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    word_next  = in_data_i;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sr_en_o = 1'b1;
                // MSB first so the word lands unreversed in the register.
                sr_x_o  = word_reg[CNT_LAST - cnt_reg];
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                out_data_o  = sr_i;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    logic mismatch_reg;

    // Sticky flag: set when the read-back frame differs from the word sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_reg <= 1'b0;
        end else if ((state_reg == DONE) && out_ready_i && (sr_i != word_reg)) begin
            mismatch_reg <= 1'b1;
        end
    end

    assign mismatch_o = mismatch_reg;
`else
    assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: emulates the driven shift register, runs
// directed frames and checks every cycle against a cycle-offset model.
module tb_shift_seq_ctrl;

    localparam int W = 4;
    localparam logic [W-1:0] FAULT_MASK = 4'b0100;
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
    localparam logic EXP_MIS_AFTER_FAULT = 1'b1;
`else
    localparam logic EXP_MIS_AFTER_FAULT = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid_i;
    logic [W-1:0] in_data_i;
    logic         in_ready_o;
    logic         sr_en_o;
    logic         sr_x_o;
    logic [W-1:0] sr_i;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
    logic         out_ready_i;
    logic         busy_o;
    logic         mismatch_o;

    logic [W-1:0] sr_q;
    logic         fault_en;
    int           stall;
    int           cyc;
    int           tests;
    int           fails;

    // Model state
    bit           m_active;
    int           m_acc_cyc;
    logic [W-1:0] m_word;
    logic         m_mis;
    int           acc_n;

    // Observation logs per accepted frame
    int           acc_log [16];
    int           fv_log  [16];
    int           vcnt_log[16];
    logic [W-1:0] data_log[16];
    logic [W-1:0] srx_log [16];

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .sr_en_o     (sr_en_o),
        .sr_x_o      (sr_x_o),
        .sr_i        (sr_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .mismatch_o  (mismatch_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External left-shifting register; fault injection flips one bit in DONE.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr_q <= '0;
        else if (sr_en_o) sr_q <= {sr_q[W-2:0], sr_x_o};
    end
    assign sr_i = sr_q ^ ((fault_en && out_valid_o) ? FAULT_MASK : '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Downstream: assert ready after 'stall' DONE cycles.
    initial begin
        int done_cnt;
        done_cnt = 0;
        out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid_o) done_cnt++;
            else done_cnt = 0;
            out_ready_i = (done_cnt > stall);
        end
    end

    // Model + compare: outputs follow from cycles elapsed since acceptance.
    always @(negedge clk) begin
        logic         e_ready, e_en, e_x, e_valid, e_busy;
        logic [W-1:0] e_data;
        int           k;
        int           idx;
        e_ready = 0; e_en = 0; e_x = 0; e_valid = 0; e_busy = 0; e_data = '0;
        k = 0;
        idx = acc_n - 1;
        if (reset_n) begin
            e_ready = !m_active;
            e_busy  = m_active;
            if (m_active) begin
                k = cyc - m_acc_cyc;
                if (k >= 1 && k <= W) begin
                    e_en = 1'b1;
                    e_x  = m_word[W-k];
                end else if (k > W) begin
                    e_valid = 1'b1;
                    e_data  = fault_en ? (m_word ^ FAULT_MASK) : m_word;
                end
            end
        end else begin
            m_mis = 1'b0;
        end
        chk("in_ready", in_ready_o, e_ready);
        chk("sr_en", sr_en_o, e_en);
        chk("sr_x", sr_x_o, e_x);
        chk("out_valid", out_valid_o, e_valid);
        chk("out_data", out_data_o, e_data);
        chk("busy", busy_o, e_busy);
        chk("mismatch", mismatch_o, m_mis);

        if (!reset_n) begin
            m_active = 0;
        end else if (m_active) begin
            if (sr_en_o) srx_log[idx] = {srx_log[idx][W-2:0], sr_x_o};
            if (out_valid_o) begin
                if (vcnt_log[idx] == 0) fv_log[idx] = cyc;
                vcnt_log[idx]++;
            end
            if (k > W && out_ready_i) begin
`ifdef SHIFT_SEQ_CTRL_CHECK_EN
                if (sr_i !== m_word) m_mis = 1'b1;
`endif
                data_log[idx] = out_data_o;
                $display("[TB] frame %0d word=%0h out_data=%0h accepted_cyc=%0d done_cyc=%0d",
                         idx, m_word, out_data_o, m_acc_cyc, cyc);
                m_active = 0;
            end
        end else if (in_valid_i) begin
            m_active  = 1;
            m_acc_cyc = cyc;
            m_word    = in_data_i;
            acc_log[acc_n] = cyc;
            acc_n++;
        end
    end

    // Present a word; returns #1 after the accepting edge with in_valid still high.
    task automatic send(input logic [W-1:0] w);
        int n;
        in_valid_i = 1'b1;
        in_data_i  = w;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready_o) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout word=%0h got=no_accept expected=accept", w);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (!busy_o) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL idle_timeout got=busy expected=idle");
                break;
            end
        end
    endtask

    task automatic wait_out_ready();
        int n;
        n = 0;
        while (1) begin
            @(posedge clk);
            #2;
            if (out_ready_i) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL ready_timeout got=0 expected=1");
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            acc_log[i] = 0; fv_log[i] = 0; vcnt_log[i] = 0;
            data_log[i] = '0; srx_log[i] = '0;
        end
        tests = 0; fails = 0; cyc = 0; acc_n = 0;
        m_active = 0; m_acc_cyc = 0; m_word = '0; m_mis = 1'b0;
        reset_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        stall = 0; fault_en = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Frame 0: basic MSB-first shift with immediate ready
        send(4'b1011); in_valid_i = 1'b0; wait_idle();

        // Frame 1: downstream stalls 3 cycles; in_valid with 5 must be ignored
        stall = 3;
        send(4'hA); in_data_i = 4'h5;
        wait_out_ready(); in_valid_i = 1'b0; stall = 0;
        wait_idle();

        // Frames 2,3: back-to-back with in_valid held
        send(4'h3); send(4'hC); in_valid_i = 1'b0; wait_idle();

        // Frame 4: reset during the third shift cycle aborts it
        send(4'h9); in_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Frame 5: normal after abort
        send(4'h6); in_valid_i = 1'b0; wait_idle();

        // Frame 6: corrupted read-back
        fault_en = 1'b1;
        send(4'h5); in_valid_i = 1'b0; wait_idle();
        fault_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mis_sticky", mismatch_o, EXP_MIS_AFTER_FAULT);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("mis_reset", mismatch_o, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("f0_bits", srx_log[0], 4'b1011);
        chk("f0_data", data_log[0], 4'hB);
        chk("f0_latency", fv_log[0] - acc_log[0], 5);
        chk("f1_data", data_log[1], 4'hA);
        chk("f1_valid_cycles", vcnt_log[1], 4);
        chk("b2b_gap", acc_log[3] - acc_log[2], 6);
        chk("f2_data", data_log[2], 4'h3);
        chk("f3_data", data_log[3], 4'hC);
        chk("abort_valid_cycles", vcnt_log[4], 0);
        chk("abort_bits", srx_log[4], 4'b0010);
        chk("f5_data", data_log[5], 4'h6);
        chk("accept_count", acc_n, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
